result_merge_buffer: RTL and testbench

Downstream consumer of the dual-pipeline/shared-resource wrapper: captures the two result streams (data + valid, no backpressure) into per-stream FIFOs and drains them round-robin onto one valid/ready output tagged with the source stream. Its output holds valid data until the consumer accepts it. When either FIFO nears full it raises `stall_req`, which drives the design's global stall, so in-flight results are absorbed without loss.

---
 rtl/merge_pkg.sv | 18 +
 rtl/merge_fifo.sv | 57 +++++
 rtl/result_merge_buffer.sv | 163 ++++++++++++++++
 tb/tb_result_merge_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared types and defaults for the result merge buffer.
package merge_pkg;

    typedef enum logic {
        SRC_1 = 1'b0,
        SRC_2 = 1'b1
    } src_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned SLACK_DEF  = 2;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/merge_fifo.sv
// Per-stream circular FIFO with push, pop and flush; flush overrides both.
module merge_fifo
    import merge_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned CNT_W  = cnt_width(DEPTH),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/result_merge_buffer.sv
// Merges two no-backpressure result streams round-robin onto one valid/ready output.
// Optional per-stream accept counters are enabled with MERGE_STATS_EN.
module result_merge_buffer
    import merge_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    parameter  int unsigned SLACK  = SLACK_DEF,
    localparam int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              flush_1,
    input  logic              flush_2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stall_req,
    output logic              overflow_1,
    output logic              overflow_2
`ifdef MERGE_STATS_EN
    ,
    output logic [31:0]       stat_cnt_1,
    output logic [31:0]       stat_cnt_2
`endif
);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SLACK);

    logic [DATA_W-1:0] w_rdata_1, w_rdata_2;
    logic [CNT_W-1:0]  w_count_1, w_count_2;
    logic              w_empty_1, w_empty_2;
    logic              w_avail_1, w_avail_2;
    logic              w_load;
    logic              w_pop_1, w_pop_2;
    logic              w_push_1, w_push_2;
    logic              w_drop_1, w_drop_2;
    logic              w_contend;

    logic [DATA_W-1:0] r_out_data;
    src_e              r_out_src;
    logic              r_out_valid;
    src_e              r_rr_next;
    logic              r_ovf_1, r_ovf_2;

    merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push_1),
        .i_pop     (w_pop_1),
        .i_flush   (flush_1),
        .i_wdata   (in_data_1),
        .o_rdata_c (w_rdata_1),
        .o_count   (w_count_1),
        .o_empty_c (w_empty_1)
    );

    merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push_2),
        .i_pop     (w_pop_2),
        .i_flush   (flush_2),
        .i_wdata   (in_data_2),
        .o_rdata_c (w_rdata_2),
        .o_count   (w_count_2),
        .o_empty_c (w_empty_2)
    );

    // A flushed stream is never a pop candidate, so the other one can still be served.
    assign w_avail_1 = !w_empty_1 && !flush_1;
    assign w_avail_2 = !w_empty_2 && !flush_2;
    assign w_load    = !r_out_valid || out_ready;
    assign w_contend = w_load && w_avail_1 && w_avail_2;

    always_comb begin
        w_pop_1 = 1'b0;
        w_pop_2 = 1'b0;
        if (w_load) begin
            if (w_avail_1 && w_avail_2) begin
                w_pop_1 = (r_rr_next == SRC_1);
                w_pop_2 = (r_rr_next == SRC_2);
            end else begin
                w_pop_1 = w_avail_1;
                w_pop_2 = w_avail_2;
            end
        end
    end

    // A full FIFO still accepts a write when it is popped on the same edge.
    assign w_push_1 = in_valid_1 && !flush_1 && ((w_count_1 < FULL_CNT) || w_pop_1);
    assign w_push_2 = in_valid_2 && !flush_2 && ((w_count_2 < FULL_CNT) || w_pop_2);
    assign w_drop_1 = in_valid_1 && !flush_1 && !w_push_1;
    assign w_drop_2 = in_valid_2 && !flush_2 && !w_push_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= SRC_1;
            r_rr_next   <= SRC_1;
            r_ovf_1     <= 1'b0;
            r_ovf_2     <= 1'b0;
        end else begin
            if (w_pop_1) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rdata_1;
                r_out_src   <= SRC_1;
            end else if (w_pop_2) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rdata_2;
                r_out_src   <= SRC_2;
            end else if (w_load) begin
                r_out_valid <= 1'b0;
            end
            if (w_contend) begin
                r_rr_next <= (r_rr_next == SRC_1) ? SRC_2 : SRC_1;
            end
            if (w_drop_1) begin
                r_ovf_1 <= 1'b1;
            end
            if (w_drop_2) begin
                r_ovf_2 <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign overflow_1 = r_ovf_1;
    assign overflow_2 = r_ovf_2;

    // Depends only on registered counts, so no input reaches the global stall.
    assign stall_req  = (w_count_1 >= STALL_CNT) || (w_count_2 >= STALL_CNT);

`ifdef MERGE_STATS_EN
    logic [31:0] r_stat_1, r_stat_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_1 <= '0;
            r_stat_2 <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_src == SRC_1) begin
                r_stat_1 <= r_stat_1 + 32'd1;
            end else begin
                r_stat_2 <= r_stat_2 + 32'd1;
            end
        end
    end

    assign stat_cnt_1 = r_stat_1;
    assign stat_cnt_2 = r_stat_2;
`endif

endmodule

// File: tb/tb_result_merge_buffer.sv
// Self-checking bench for result_merge_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_result_merge_buffer;

    localparam int DEPTH = 4;
    localparam int SLACK = 2;

    logic        clk;
    logic        reset;
    logic [31:0] in_data_1, in_data_2;
    logic        in_valid_1, in_valid_2;
    logic        flush_1, flush_2;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_valid;
    logic        out_ready;
    logic        stall_req;
    logic        overflow_1, overflow_2;
`ifdef MERGE_STATS_EN
    logic [31:0] stat_cnt_1, stat_cnt_2;
`endif

    int checks;
    int failures;

    // Reference model state
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_src;
    bit          m_rr;
    bit          m_ovf1, m_ovf2;
    int unsigned m_stat1, m_stat2;

    // Words seen accepted at the DUT output
    logic [31:0] acc_data[$];
    bit          acc_src[$];

    result_merge_buffer #(.DATA_W(32), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data_1  (in_data_1),
        .in_data_2  (in_data_2),
        .in_valid_1 (in_valid_1),
        .in_valid_2 (in_valid_2),
        .flush_1    (flush_1),
        .flush_2    (flush_2),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stall_req  (stall_req),
        .overflow_1 (overflow_1),
        .overflow_2 (overflow_2)
`ifdef MERGE_STATS_EN
        ,
        .stat_cnt_1 (stat_cnt_1),
        .stat_cnt_2 (stat_cnt_2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q1.delete();
        q2.delete();
        m_valid = 0;
        m_data  = '0;
        m_src   = 0;
        m_rr    = 0;
        m_ovf1  = 0;
        m_ovf2  = 0;
        m_stat1 = 0;
        m_stat2 = 0;
    endtask

    // Applies one cycle of inputs, advances the model, ends 1ns after the edge.
    task automatic cycle(input bit v1, input logic [31:0] d1, input bit v2, input logic [31:0] d2,
                         input bit f1, input bit f2, input bit rdy);
        bit load, a1, a2, p1, p2;
        in_valid_1 = v1; in_data_1 = d1;
        in_valid_2 = v2; in_data_2 = d2;
        flush_1    = f1; flush_2   = f2;
        out_ready  = rdy;
        if (out_valid && rdy) begin
            acc_data.push_back(out_data);
            acc_src.push_back(out_src);
        end
        if (m_valid && rdy) begin
            if (m_src) m_stat2++; else m_stat1++;
        end
        load = !m_valid || rdy;
        a1 = (q1.size() != 0) && !f1;
        a2 = (q2.size() != 0) && !f2;
        p1 = 0; p2 = 0;
        if (load) begin
            if (a1 && a2) begin
                if (m_rr == 0) p1 = 1; else p2 = 1;
                m_rr = !m_rr;
            end else begin
                p1 = a1;
                p2 = a2;
            end
        end
        if (p1) begin
            m_data = q1.pop_front(); m_src = 0; m_valid = 1;
        end else if (p2) begin
            m_data = q2.pop_front(); m_src = 1; m_valid = 1;
        end else if (load) begin
            m_valid = 0;
        end
        if (f1) q1.delete();
        if (f2) q2.delete();
        if (v1 && !f1) begin
            if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf1 = 1;
        end
        if (v2 && !f2) begin
            if (q2.size() < DEPTH) q2.push_back(d2); else m_ovf2 = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid_1 = 0; in_valid_2 = 0; flush_1 = 0; flush_2 = 0; out_ready = 0;
        in_data_1 = '0; in_data_2 = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        acc_data.delete();
        acc_src.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid_1 = 0; in_valid_2 = 0; flush_1 = 0; flush_2 = 0; out_ready = 0;
        in_data_1 = '0; in_data_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_src !== 1'b0) begin failures++; $display("FAIL reset_src got=%b exp=0", out_src); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        checks++; if ({overflow_1, overflow_2} !== 2'b00) begin failures++; $display("FAIL reset_ovf got=%b%b exp=00", overflow_1, overflow_2); end
`ifdef MERGE_STATS_EN
        checks++; if ({stat_cnt_1, stat_cnt_2} !== 64'h0) begin failures++; $display("FAIL reset_stats got=%0d,%0d exp=0,0", stat_cnt_1, stat_cnt_2); end
`endif
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 32'hA5A5_0001, 0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_lat1 got=%b exp=0", out_valid); end
        cycle(0, 0, 0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data got=%h exp=a5a50001", out_data); end
        checks++; if (out_src !== 1'b0) begin failures++; $display("FAIL single_src got=%b exp=0", out_src); end
        cycle(0, 0, 0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_d;
        bit          exp_s;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h100 + i, 1, 32'h200 + i, 0, 0, 1);
        idle(8, 1);
        checks++; if (acc_data.size() !== 8) begin failures++; $display("FAIL cont_count got=%0d exp=8", acc_data.size()); end
        for (int k = 0; k < acc_data.size() && k < 8; k++) begin
            exp_s = k[0];
            exp_d = (exp_s ? 32'h200 : 32'h100) + 32'(k / 2);
            checks++; if (acc_src[k] !== exp_s) begin failures++; $display("FAIL cont_src[%0d] got=%b exp=%b", k, acc_src[k], exp_s); end
            checks++; if (acc_data[k] !== exp_d) begin failures++; $display("FAIL cont_data[%0d] got=%h exp=%h", k, acc_data[k], exp_d); end
        end
        checks++; if ({overflow_1, overflow_2} !== 2'b00) begin failures++; $display("FAIL cont_ovf got=%b%b exp=00", overflow_1, overflow_2); end
    endtask

    task automatic test_stall_overflow();
        bit exp_stall [5] = '{0, 0, 1, 1, 1};
        do_reset();
        cycle(0, 0, 1, 32'h0F, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 32'h10 + i, 0, 0, 0);
            if (i < 4) begin
                checks++; if (stall_req !== exp_stall[i + 1]) begin failures++; $display("FAIL stall_w%0d got=%b exp=%b", i, stall_req, exp_stall[i + 1]); end
                checks++; if (overflow_2 !== 1'b0) begin failures++; $display("FAIL ovf_early_w%0d got=%b exp=0", i, overflow_2); end
            end
        end
        checks++; if (overflow_2 !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_2); end
        acc_data.delete();
        acc_src.delete();
        idle(8, 1);
        checks++; if (acc_data.size() !== 5) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=5", acc_data.size()); end
        for (int k = 0; k < acc_data.size() && k < 5; k++) begin
            checks++; if (acc_data[k] !== 32'h0F + 32'(k) || acc_src[k] !== 1'b1) begin
                failures++; $display("FAIL ovf_drain[%0d] got=%h/%b exp=%h/1", k, acc_data[k], acc_src[k], 32'h0F + 32'(k));
            end
        end
        checks++; if (overflow_2 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_2); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_fall got=%b exp=0", stall_req); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h30 + i, 0, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%b exp=1", stall_req); end
        cycle(1, 32'h34, 0, 0, 1, 0, 0);
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_req); end
        checks++; if (overflow_1 !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", overflow_1); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h30) begin failures++; $display("FAIL flush_hold got=%b/%h exp=1/30", out_valid, out_data); end
        acc_data.delete();
        acc_src.delete();
        idle(5, 1);
        checks++; if (acc_data.size() !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", acc_data.size()); end
        if (acc_data.size() >= 1) begin
            checks++; if (acc_data[0] !== 32'h30) begin failures++; $display("FAIL flush_word got=%h exp=30", acc_data[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 32'h50 + i, 0, 0, 0, 0, 0);
        checks++; if (overflow_1 !== 1'b1 || stall_req !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b%b exp=11", overflow_1, stall_req); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (stall_req !== 1'b0 || overflow_1 !== 1'b0) begin failures++; $display("FAIL mid_clear got=%b%b exp=00", stall_req, overflow_1); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle(3, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_fresh got=%b exp=0", out_valid); end
    endtask

`ifdef MERGE_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h70 + i, (i < 3), 32'h80 + i, 0, 0, 1);
        idle(10, 1);
        checks++; if (stat_cnt_1 !== 32'd5) begin failures++; $display("FAIL stat1 got=%0d exp=5", stat_cnt_1); end
        checks++; if (stat_cnt_2 !== 32'd3) begin failures++; $display("FAIL stat2 got=%0d exp=3", stat_cnt_2); end
        cycle(1, 32'h90, 1, 32'h91, 0, 0, 1);
        cycle(1, 32'h92, 1, 32'h93, 0, 0, 1);
        reset = 1'b1;
        #1;
        checks++; if ({stat_cnt_1, stat_cnt_2} !== 64'h0) begin failures++; $display("FAIL stat_reset got=%0d,%0d exp=0,0", stat_cnt_1, stat_cnt_2); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask
`endif

    task automatic test_random();
        bit v1, v2, f1, f2, rdy, exp_stall;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v1  = ($urandom_range(0, 1) == 1);
            v2  = ($urandom_range(0, 2) != 0);
            f1  = ($urandom_range(0, 19) == 0);
            f2  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 4) > ((n / 150) % 2 == 0 ? 1 : 3));
            cycle(v1, $urandom, v2, $urandom, f1, f2, rdy);
            exp_stall = (q1.size() >= DEPTH - SLACK) || (q2.size() >= DEPTH - SLACK);
            checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid@%0d got=%b exp=%b", n, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (out_data !== m_data) begin failures++; $display("FAIL rnd_data@%0d got=%h exp=%h", n, out_data, m_data); end
                checks++; if (out_src !== m_src) begin failures++; $display("FAIL rnd_src@%0d got=%b exp=%b", n, out_src, m_src); end
            end
            checks++; if (stall_req !== exp_stall) begin failures++; $display("FAIL rnd_stall@%0d got=%b exp=%b", n, stall_req, exp_stall); end
            checks++; if (overflow_1 !== m_ovf1 || overflow_2 !== m_ovf2) begin
                failures++; $display("FAIL rnd_ovf@%0d got=%b%b exp=%b%b", n, overflow_1, overflow_2, m_ovf1, m_ovf2);
            end
`ifdef MERGE_STATS_EN
            checks++; if (stat_cnt_1 !== m_stat1 || stat_cnt_2 !== m_stat2) begin
                failures++; $display("FAIL rnd_stats@%0d got=%0d,%0d exp=%0d,%0d", n, stat_cnt_1, stat_cnt_2, m_stat1, m_stat2);
            end
`endif
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_stall_overflow();
        test_flush();
        test_reset_mid();
`ifdef MERGE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
